spi_peripheral: RTL and testbench

- SPI responder (target) for CPOL=0/CPHA=0 buses. It is the far end of our SPI controller blocks and is used to emulate SPI devices in simulation, or to expose FPGA registers and memories to an external SPI initiator.
- All SPI inputs are oversampled and synchronised into `clock`.
- Received bytes are emitted as single-cycle strobes, each with a byte index within the frame.
- Transmit bytes are supplied through a one-byte ready/valid holding buffer.

---
 rtl/spi_peripheral_if.sv | 38 +++
 rtl/spi_peripheral.sv | 201 ++++++++++++++++++++
 tb/tb_spi_peripheral.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_peripheral_if.sv
// rtl/spi_peripheral_if.sv - user-side byte stream and frame event bundle for spi_peripheral
//
// Purpose: groups the transmit holding-buffer handshake, the receive strobe and
//          the per-frame event strobes of spi_peripheral.
// Signals:
//   tx_data/tx_valid/tx_ready   next byte to transmit (write when valid && ready)
//   rx_data/rx_valid            received byte, one-cycle strobe
//   write_address               byte index within frame, valid with rx_valid
//   frame_start/frame_end       select assertion / deassertion strobes
//   frame_error                 select deasserted mid-byte
//   tx_underrun                 idle byte substituted for an empty tx buffer
// Modports: master = user logic, slave = the SPI peripheral.
interface spi_peripheral_if #(
  parameter int output_address_length = 24
);
  logic [7:0]                       tx_data;
  logic                             tx_valid;
  logic                             tx_ready;
  logic [7:0]                       rx_data;
  logic                             rx_valid;
  logic [output_address_length-1:0] write_address;
  logic                             frame_start;
  logic                             frame_end;
  logic                             frame_error;
  logic                             tx_underrun;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, write_address,
           frame_start, frame_end, frame_error, tx_underrun
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, write_address,
           frame_start, frame_end, frame_error, tx_underrun
  );
endinterface

// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - oversampled SPI mode-0 responder with byte strobes and tx holding buffer
//
// Purpose: SPI target for CPOL=0/CPHA=0. SPI pins are synchronised into clock,
//          received bytes leave as strobes with a per-frame byte index, and
//          transmit bytes come from a one-byte ready/valid holding buffer.
// Ports:
//   clock, reset           system clock, synchronous active-high reset
//   mem_clk, mem_ps        SPI clock (idles low) and active-low select
//   mem_copi               data from the initiator
//   mem_cipo, mem_cipo_oe  data to the initiator and its tristate enable
//   bus                    spi_peripheral_if.slave user-side streams and strobes
module spi_peripheral #(
  parameter int         sync_stages           = 2,
  parameter int         output_address_length = 24,
  parameter logic [7:0] idle_byte             = 8'hff
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_clk,
  input  logic              mem_ps,
  input  logic              mem_copi,
  output logic              mem_cipo,
  output logic              mem_cipo_oe,
  spi_peripheral_if.slave   bus
);

  localparam logic [output_address_length-1:0] addr_one = 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_next;

  logic [sync_stages-1:0] clk_sync, ps_sync, copi_sync;
  logic s_clk, s_ps, s_copi;
  logic clk_d, ps_d;
  logic rise, fall, sel_on, sel_off;

  logic [7:0] tx_buf;
  logic       tx_full;
  logic [7:0] shift;
  logic [7:0] rx_shift;
  logic [2:0] bit_count;
  logic       byte_done;
  logic       got_rise;

  logic [7:0]                       rx_data_q;
  logic                             rx_valid_q;
  logic [output_address_length-1:0] waddr;
  logic frame_start_q, frame_end_q, frame_error_q, tx_underrun_q;

  logic do_start, do_end, do_rx, do_fall;

  // Select synchroniser resets to "selected" so a select already low when
  // reset releases produces no sel_on; only a genuine high->low does.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync  <= '0;
      ps_sync   <= '0;
      copi_sync <= '0;
      clk_d     <= 1'b0;
      ps_d      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[sync_stages-2:0], mem_clk};
      ps_sync   <= {ps_sync[sync_stages-2:0], mem_ps};
      copi_sync <= {copi_sync[sync_stages-2:0], mem_copi};
      clk_d     <= s_clk;
      ps_d      <= s_ps;
    end
  end

  assign s_clk   = clk_sync[sync_stages-1];
  assign s_ps    = ps_sync[sync_stages-1];
  assign s_copi  = copi_sync[sync_stages-1];
  assign rise    = s_clk & ~clk_d;
  assign fall    = ~s_clk & clk_d;
  assign sel_on  = ~s_ps & ps_d;
  assign sel_off = s_ps & ~ps_d;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sel_on)  state_next = ACTIVE;
      ACTIVE:  if (sel_off) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // sel_off wins over a coincident clock edge; falls before the first rise
  // of a frame carry no data and are ignored.
  always_comb begin
    mem_cipo_oe = 1'b0;
    do_start    = 1'b0;
    do_end      = 1'b0;
    do_rx       = 1'b0;
    do_fall     = 1'b0;
    case (state)
      IDLE: do_start = sel_on;
      ACTIVE: begin
        mem_cipo_oe = 1'b1;
        if (sel_off) begin
          do_end = 1'b1;
        end else begin
          do_rx   = rise;
          do_fall = fall & got_rise;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_buf        <= '0;
      tx_full       <= 1'b0;
      shift         <= '0;
      rx_shift      <= '0;
      bit_count     <= '0;
      byte_done     <= 1'b0;
      got_rise      <= 1'b0;
      mem_cipo      <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      waddr         <= '0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_error_q <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      rx_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_error_q <= 1'b0;
      tx_underrun_q <= 1'b0;

      mem_cipo <= shift[7];

      // Address advances in the strobe cycle so rx_valid carries the old index.
      if (rx_valid_q) waddr <= waddr + addr_one;

      // A write needs an empty buffer and a consume a full one, so the two
      // updates of tx_full below never collide.
      if (bus.tx_valid && !tx_full) begin
        tx_buf  <= bus.tx_data;
        tx_full <= 1'b1;
      end

      if (do_start || (do_fall && byte_done)) begin
        if (tx_full) begin
          shift   <= tx_buf;
          tx_full <= 1'b0;
        end else begin
          shift         <= idle_byte;
          tx_underrun_q <= 1'b1;
        end
      end else if (do_fall) begin
        shift <= {shift[6:0], 1'b0};
      end

      if (do_fall) byte_done <= 1'b0;

      if (do_rx) begin
        rx_shift  <= {rx_shift[6:0], s_copi};
        bit_count <= bit_count + 3'd1;
        got_rise  <= 1'b1;
        if (bit_count == 3'd7) begin
          rx_data_q  <= {rx_shift[6:0], s_copi};
          rx_valid_q <= 1'b1;
          byte_done  <= 1'b1;
        end
      end

      if (do_start) begin
        frame_start_q <= 1'b1;
        waddr         <= '0;
        bit_count     <= '0;
        byte_done     <= 1'b0;
        got_rise      <= 1'b0;
      end

      if (do_end) begin
        frame_end_q   <= 1'b1;
        frame_error_q <= (bit_count != 3'd0);
      end
    end
  end

  assign bus.tx_ready      = ~tx_full;
  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.write_address = waddr;
  assign bus.frame_start   = frame_start_q;
  assign bus.frame_end     = frame_end_q;
  assign bus.frame_error   = frame_error_q;
  assign bus.tx_underrun   = tx_underrun_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// tb/tb_spi_peripheral.sv - scoreboard testbench for spi_peripheral
module tb_spi_peripheral;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic mem_clk  = 1'b0;
  logic mem_ps   = 1'b1;
  logic mem_copi = 1'b0;
  logic use2     = 1'b0;
  logic mem_ps2;
  assign mem_ps2 = use2 ? mem_ps : 1'b1;

  logic cipo1, oe1, cipo2, oe2;

  spi_peripheral_if #(.output_address_length(24)) bus1();
  spi_peripheral_if #(.output_address_length(2))  bus2();

  spi_peripheral #(.sync_stages(2), .output_address_length(24), .idle_byte(8'hff)) dut1 (
    .clock(clock), .reset(reset), .mem_clk(mem_clk), .mem_ps(mem_ps), .mem_copi(mem_copi),
    .mem_cipo(cipo1), .mem_cipo_oe(oe1), .bus(bus1)
  );

  spi_peripheral #(.sync_stages(2), .output_address_length(2), .idle_byte(8'hff)) dut2 (
    .clock(clock), .reset(reset), .mem_clk(mem_clk), .mem_ps(mem_ps2), .mem_copi(mem_copi),
    .mem_cipo(cipo2), .mem_cipo_oe(oe2), .bus(bus2)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         addr;
  } rx_t;

  rx_t  exp1[$];
  rx_t  exp2[$];
  logic exp_err[$];
  rx_t  e1, e2;

  int n_start = 0, n_end = 0, n_underrun = 0, n_rx = 0;

  // Monitor: pops expectations whenever the DUTs present a strobe.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus1.rx_valid) begin
        n_rx++;
        if (exp1.size() == 0) check("rx1_unexpected", 32'(bus1.rx_data), 32'hffff_ffff);
        else begin
          e1 = exp1.pop_front();
          check("rx1_data", 32'(bus1.rx_data), 32'(e1.data));
          check("rx1_addr", 32'(bus1.write_address), 32'(e1.addr));
        end
      end
      if (bus2.rx_valid) begin
        if (exp2.size() == 0) check("rx2_unexpected", 32'(bus2.rx_data), 32'hffff_ffff);
        else begin
          e2 = exp2.pop_front();
          check("rx2_data", 32'(bus2.rx_data), 32'(e2.data));
          check("rx2_addr", 32'(bus2.write_address), 32'(e2.addr));
        end
      end
      if (bus1.frame_start) n_start++;
      if (bus1.tx_underrun) n_underrun++;
      if (bus1.frame_end) begin
        n_end++;
        if (exp_err.size() == 0) check("frame_end_unexpected", 32'd1, 32'd0);
        else check("frame_error_with_end", 32'(bus1.frame_error), 32'(exp_err.pop_front()));
        check("oe_drops_with_end", 32'(oe1), 32'd0);
      end else if (bus1.frame_error) begin
        check("frame_error_alone", 32'd1, 32'd0);
      end
    end
  end

  task automatic spi_bit(input logic b, output logic r);
    mem_copi = b;
    repeat (4) @(negedge clock);
    r = cipo1;
    mem_clk = 1'b1;
    repeat (4) @(negedge clock);
    mem_clk = 1'b0;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    logic r;
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic sel_low();
    mem_ps = 1'b0;
    repeat (6) @(negedge clock);
  endtask

  task automatic end_frame();
    repeat (4) @(negedge clock);
    mem_ps = 1'b1;
    repeat (6) @(negedge clock);
  endtask

  task automatic tx_push(input logic [7:0] d);
    int k;
    @(negedge clock);
    bus1.tx_data  = d;
    bus1.tx_valid = 1'b1;
    k = 0;
    while (!bus1.tx_ready && k < 200) begin
      @(negedge clock);
      k++;
    end
    if (k >= 200) check("tx_push_timeout", 32'd1, 32'd0);
    @(negedge clock);
    bus1.tx_valid = 1'b0;
    check("tx_ready_after_write", 32'(bus1.tx_ready), 32'd0);
  endtask

  task automatic expect1(input logic [7:0] d, input int a);
    rx_t t;
    t.data = d;
    t.addr = a;
    exp1.push_back(t);
  endtask

  task automatic expect2(input logic [7:0] d, input int a);
    rx_t t;
    t.data = d;
    t.addr = a;
    exp2.push_back(t);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    int s0, e0, u0, rx0;
    bus1.tx_data = 8'h00;
    bus1.tx_valid = 1'b0;
    bus2.tx_data = 8'h00;
    bus2.tx_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_cipo", 32'(cipo1), 32'd0);
    check("rst_oe", 32'(oe1), 32'd0);
    check("rst_tx_ready", 32'(bus1.tx_ready), 32'd1);
    check("rst_rx_data", 32'(bus1.rx_data), 32'd0);
    check("rst_rx_valid", 32'(bus1.rx_valid), 32'd0);
    check("rst_waddr", 32'(bus1.write_address), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // 1-byte frame, preloaded 0x3C, receive 0xA5
    tx_push(8'h3c);
    expect1(8'ha5, 0);
    exp_err.push_back(1'b0);
    s0 = n_start;
    sel_low();
    check("t1_frame_start", 32'(n_start - s0), 32'd1);
    check("t1_tx_ready_after_sel", 32'(bus1.tx_ready), 32'd1);
    check("t1_oe_active", 32'(oe1), 32'd1);
    spi_bits(8'ha5, 8, r);
    check("t1_cipo_byte", 32'(r), 32'h3c);
    e0 = n_end;
    end_frame();
    check("t1_frame_end", 32'(n_end - e0), 32'd1);
    check("t1_rx_drained", 32'(exp1.size()), 32'd0);

    // 3-byte frame with refill, one underrun on the third byte
    tx_push(8'h10);
    expect1(8'h01, 0);
    expect1(8'h02, 1);
    expect1(8'h03, 2);
    exp_err.push_back(1'b0);
    sel_low();
    tx_push(8'h20);
    u0 = n_underrun;
    spi_bits(8'h01, 8, r);
    check("t2_cipo_b0", 32'(r), 32'h10);
    spi_bits(8'h02, 8, r);
    check("t2_cipo_b1", 32'(r), 32'h20);
    spi_bits(8'h03, 8, r);
    check("t2_cipo_b2", 32'(r), 32'hff);
    repeat (1) @(negedge clock);
    check("t2_underruns", 32'(n_underrun - u0), 32'd1);
    end_frame();
    check("t2_rx_drained", 32'(exp1.size()), 32'd0);

    // Partial byte: frame_error with frame_end, then clean frame from address 0
    exp_err.push_back(1'b1);
    rx0 = n_rx;
    sel_low();
    spi_bits(8'hc0, 5, r);
    end_frame();
    check("t3_no_rx_partial", 32'(n_rx - rx0), 32'd0);
    expect1(8'h5a, 0);
    exp_err.push_back(1'b0);
    sel_low();
    spi_bits(8'h5a, 8, r);
    end_frame();
    check("t3_rx_drained", 32'(exp1.size()), 32'd0);

    // tx_valid held while buffer full: second byte ignored
    @(negedge clock);
    bus1.tx_data = 8'h77;
    bus1.tx_valid = 1'b1;
    @(negedge clock);
    bus1.tx_data = 8'h88;
    repeat (5) @(negedge clock);
    check("t4_tx_ready_low", 32'(bus1.tx_ready), 32'd0);
    bus1.tx_valid = 1'b0;
    expect1(8'h00, 0);
    exp_err.push_back(1'b0);
    sel_low();
    check("t4_tx_ready_back", 32'(bus1.tx_ready), 32'd1);
    spi_bits(8'h00, 8, r);
    check("t4_first_capture", 32'(r), 32'h77);
    end_frame();
    tx_push(8'h88);
    expect1(8'h00, 0);
    exp_err.push_back(1'b0);
    sel_low();
    spi_bits(8'h00, 8, r);
    check("t4_second_capture", 32'(r), 32'h88);
    end_frame();

    // Reset mid-byte with select held low
    sel_low();
    tx_push(8'h33);
    spi_bits(8'hf0, 3, r);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("t5_cipo", 32'(cipo1), 32'd0);
    check("t5_oe", 32'(oe1), 32'd0);
    check("t5_tx_ready", 32'(bus1.tx_ready), 32'd1);
    check("t5_rx_data", 32'(bus1.rx_data), 32'd0);
    check("t5_waddr", 32'(bus1.write_address), 32'd0);
    check("t5_strobes", 32'({bus1.rx_valid, bus1.frame_start, bus1.frame_end,
                              bus1.frame_error, bus1.tx_underrun}), 32'd0);
    reset = 1'b0;
    s0 = n_start;
    e0 = n_end;
    u0 = n_underrun;
    rx0 = n_rx;
    repeat (4) @(negedge clock);
    spi_bits(8'hc3, 8, r);
    check("t5_oe_idle", 32'(oe1), 32'd0);
    end_frame();
    check("t5_no_rx", 32'(n_rx - rx0), 32'd0);
    check("t5_no_start", 32'(n_start - s0), 32'd0);
    check("t5_no_end", 32'(n_end - e0), 32'd0);
    check("t5_no_underrun", 32'(n_underrun - u0), 32'd0);
    expect1(8'hc3, 0);
    exp_err.push_back(1'b0);
    sel_low();
    spi_bits(8'hc3, 8, r);
    end_frame();
    check("t5_rx_drained", 32'(exp1.size()), 32'd0);

    // 2-bit address counter wraps after four bytes
    use2 = 1'b1;
    expect1(8'h11, 0); expect1(8'h22, 1); expect1(8'h33, 2); expect1(8'h44, 3); expect1(8'h55, 4);
    expect2(8'h11, 0); expect2(8'h22, 1); expect2(8'h33, 2); expect2(8'h44, 3); expect2(8'h55, 0);
    exp_err.push_back(1'b0);
    sel_low();
    check("t6_cipo2_idle_byte", 32'(cipo2), 32'd1);
    spi_bits(8'h11, 8, r);
    spi_bits(8'h22, 8, r);
    spi_bits(8'h33, 8, r);
    spi_bits(8'h44, 8, r);
    spi_bits(8'h55, 8, r);
    end_frame();
    use2 = 1'b0;
    check("t6_oe2_idle", 32'(oe2), 32'd0);
    check("t6_rx2_drained", 32'(exp2.size()), 32'd0);

    repeat (10) @(negedge clock);
    check("final_rx1_drained", 32'(exp1.size()), 32'd0);
    check("final_end_drained", 32'(exp_err.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
